// File: rtl/rv_pkg.sv
// Shared definitions for the boot loader and instruction memory.
// State codes are plain localparams so legacy tools read them as constants.
package rv_pkg;

    localparam int IMEM_DEPTH_WORDS = 64;

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t LEN0 = 3'd0;
    localparam loader_state_t LEN1 = 3'd1;
    localparam loader_state_t DATA = 3'd2;
    localparam loader_state_t CSUM = 3'd3;
    localparam loader_state_t DONE = 3'd4;
    localparam loader_state_t ERR  = 3'd5;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler for the program loader.
// Raises o_word_ready for one cycle after the fourth byte of a word is taken.
module byte_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_take,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_ready
);

    logic [WIDTH-1:0] r_word;
    logic [1:0]       r_byte_idx;
    logic             r_word_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word       <= '0;
            r_byte_idx   <= 2'd0;
            r_word_ready <= 1'b0;
        end else if (i_clear) begin
            r_word       <= '0;
            r_byte_idx   <= 2'd0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= i_take && (r_byte_idx == 2'd3);
            if (i_take) begin
                r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte;
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = r_word_ready;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, little-endian words into imem, then core release.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import rv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             reload,
    output logic             imem_we,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] imem_wdata,
    output logic             core_rst,
    output logic             done,
    output logic             error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = CSUM;
`else
    localparam loader_state_t END_STATE = DONE;
`endif

    loader_state_t    r_state;
    logic             r_armed;
    logic [7:0]       r_len_lo;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_word_idx;

    logic             w_take;
    logic             w_restart;
    logic             w_word_ready;
    logic             w_last;
    logic [IDX_W-1:0] w_idx_next;
    logic [CNT_W-1:0] w_n;
    logic [WIDTH-1:0] w_word;

    assign w_take     = rx_valid && rx_ready;
    assign w_restart  = reload && ((r_state == DONE) || (r_state == ERR));
    assign w_idx_next = r_word_idx + 1'b1;
    assign w_n        = {rx_data, r_len_lo};
    assign w_last     = w_word_ready && ({{(CNT_W-IDX_W){1'b0}}, w_idx_next} == r_count);

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_restart),
        .i_take       (w_take && (r_state == DATA)),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // Bytes are refused during the final write so nothing leaks past the image.
    always_comb begin
        rx_ready = 1'b0;
        if (r_armed) begin
            case (r_state)
                LEN0, LEN1: rx_ready = 1'b1;
                DATA:       rx_ready = !w_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM:       rx_ready = 1'b1;
`endif
                default:    rx_ready = 1'b0;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xor <= 8'h00;
        end else if (w_restart) begin
            r_xor <= 8'h00;
        end else if (w_take && (r_state == DATA)) begin
            r_xor <= r_xor ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LEN0;
            r_armed    <= 1'b0;
            r_len_lo   <= 8'h00;
            r_count    <= '0;
            r_word_idx <= '0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                LEN0: begin
                    if (w_take) begin
                        r_len_lo <= rx_data;
                        r_state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (w_take) begin
                        r_count <= w_n;
                        if (w_n == '0)
                            r_state <= END_STATE;
                        else if (w_n > CNT_W'(DEPTH_WORDS))
                            r_state <= ERR;
                        else
                            r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_word_ready) begin
                        r_word_idx <= w_idx_next;
                        if (w_last)
                            r_state <= END_STATE;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (w_take)
                        r_state <= (rx_data == r_xor) ? DONE : ERR;
                end
`endif
                DONE, ERR: begin
                    if (reload) begin
                        r_state    <= LEN0;
                        r_word_idx <= '0;
                    end
                end
                default: r_state <= LEN0;
            endcase
        end
    end

    assign imem_we    = w_word_ready && (r_state == DATA);
    assign imem_addr  = {{(WIDTH-IDX_W-2){1'b0}}, r_word_idx, 2'b00};
    assign imem_wdata = w_word;
    assign core_rst   = (r_state != DONE);
    assign done       = (r_state == DONE);
    assign error      = (r_state == ERR);

endmodule
